// File: rtl/mem_sram_ctrl_pkg.sv
// Shared memory request/response payloads and SRAM controller FSM encoding.
package mem_sram_ctrl_pkg;

    localparam int unsigned MEM_ADDR_WIDTH  = 32;
    localparam int unsigned MEM_DATA_WIDTH  = 32;
    localparam int unsigned MEM_BE_WIDTH    = MEM_DATA_WIDTH / 8;
    localparam int unsigned SRAM_WAIT_WIDTH = 4;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [MEM_DATA_WIDTH-1:0] wdata;
        logic [MEM_BE_WIDTH-1:0]   be;
    } mreq_t;

    typedef struct packed {
        logic [MEM_DATA_WIDTH-1:0] rdata;
    } mresp_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RESP
    } sram_state_e;

endpackage

// File: rtl/mem_sram_ctrl.sv
// Single-bank async SRAM controller: one access in flight, one in-order response per request.
// Optional MEM_SRAM_CTRL_RESP_REG_EN lets the FSM return to IDLE while a response is still draining.
module mem_sram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned READ_WAIT  = 2,
    parameter int unsigned WRITE_WAIT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
    input  logic                    req_we,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    inout  wire  [DATA_WIDTH-1:0]   sram_data,
    output logic                    sram_ce_n,
    output logic                    sram_oe_n,
    output logic                    sram_we_n,
    output logic [DATA_WIDTH/8-1:0] sram_be_n
);
    import mem_sram_ctrl_pkg::*;

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [SRAM_WAIT_WIDTH-1:0] RD_CNT = SRAM_WAIT_WIDTH'(READ_WAIT);
    localparam logic [SRAM_WAIT_WIDTH-1:0] WR_CNT = SRAM_WAIT_WIDTH'(WRITE_WAIT);
    localparam logic [SRAM_WAIT_WIDTH-1:0] CNT_ONE = SRAM_WAIT_WIDTH'(1);

    sram_state_e                state_q, state_d;
    logic [SRAM_WAIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [BE_WIDTH-1:0]        be_q, be_src_c;
    logic [DATA_WIDTH-1:0]      rdata_d;
    logic                       resp_valid_d;
    logic                       drive_q, drive_d;
    logic                       ce_n_d, oe_n_d, we_n_d;
    logic [BE_WIDTH-1:0]        be_n_d;
    logic                       accept_c, resp_hs_c;
    logic                       unused_addr_c;

`ifdef MEM_SRAM_CTRL_RESP_REG_EN
    // Completion loads the response register and frees the FSM immediately.
    localparam sram_state_e DONE_STATE = IDLE;
    assign req_ready = rst && (state_q == IDLE) && (!resp_valid || resp_ready);
`else
    localparam sram_state_e DONE_STATE = RESP;
    assign req_ready = rst && (state_q == IDLE);
`endif

    assign accept_c      = req_valid && req_ready;
    assign resp_hs_c     = resp_valid && resp_ready;
    assign sram_data     = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign unused_addr_c = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

    // Next state, wait counter and response; strobes decoded from the next state so they leave flops.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rdata_d      = resp_rdata;
        resp_valid_d = resp_valid;
        ce_n_d       = 1'b1;
        oe_n_d       = 1'b1;
        we_n_d       = 1'b1;
        be_n_d       = '1;
        drive_d      = 1'b0;
        be_src_c     = (state_q == IDLE) ? req_be : be_q;

        if (resp_hs_c) begin
            resp_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = req_we ? WR_SETUP : RD;
                    cnt_d   = req_we ? WR_CNT : RD_CNT;
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    rdata_d      = sram_data;
                    resp_valid_d = 1'b1;
                    state_d      = DONE_STATE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WR_HOLD: begin
                rdata_d      = '0;
                resp_valid_d = 1'b1;
                state_d      = DONE_STATE;
            end
            RESP: begin
                if (resp_hs_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
            end
            WR_SETUP, WR_HOLD: begin
                ce_n_d  = 1'b0;
                be_n_d  = ~be_src_c;
                drive_d = 1'b1;
            end
            WR_PULSE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                be_n_d  = ~be_src_c;
                drive_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, strobes and latched request; reset forces every strobe high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= '1;
            sram_addr  <= '0;
            drive_q    <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= rdata_d;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            sram_be_n  <= be_n_d;
            drive_q    <= drive_d;
            if (accept_c) begin
                sram_addr <= req_addr[ADDR_WIDTH+1:2];
                wdata_q   <= req_wdata;
                be_q      <= req_be;
            end
        end
    end

endmodule
